// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain stage serialising bytes as asynchronous UART frames
//
// Pops bytes from a first-word-fall-through FIFO and sends each as
// start bit, 8 data bits LSB first, optional parity bit, one stop bit.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      permits starting new frames; an active frame always completes
//   fifo_data   FIFO head byte, valid while fifo_empty is low
//   fifo_empty  FIFO empty flag
//   fifo_read   pop strobe to the FIFO (combinational)
//   tx          serial line, idle high, registered
//   busy        high while a frame is in progress
//   frame_done  one-cycle pulse in the last clk of each stop bit
//   bytes_sent  completed frame count, wraps modulo 2^16
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_read,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] bytes_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic [15:0] bytes_q, bytes_d;

    logic last_tick;
    logic pop;

    assign last_tick = (baud_cnt_q == LAST_CNT);

    // Gated by rst_n so nothing is popped while the block is held in reset.
    assign pop = enable & ~fifo_empty & rst_n &
                 ((state_q == S_IDLE) | ((state_q == S_STOP) & last_tick));

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = (state_q == S_IDLE || last_tick) ? 16'd0 : baud_cnt_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bytes_d    = bytes_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d  = S_START;
                    shift_d  = fifo_data;
                    parity_d = (^fifo_data) ^ PARITY_ODD;
                end
            end
            S_START: begin
                if (last_tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (last_tick) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    bytes_d = bytes_q + 16'd1;
                    // Back-to-back: the next byte is captured in the same cycle.
                    if (pop) begin
                        state_d  = S_START;
                        shift_d  = fifo_data;
                        parity_d = (^fifo_data) ^ PARITY_ODD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tx is registered, so it is derived from the state being entered.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            bytes_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            bytes_q    <= bytes_d;
        end
    end

    assign fifo_read  = pop;
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) & last_tick;
    assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

    logic        clk;
    logic        rst_n;
    logic        enable;

    // Main DUT: 4 clks per bit, no parity, fed from a small FIFO model.
    logic [7:0]  mem [16];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_read;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [15:0] bytes_sent;

    // Parity DUTs (even and odd) share a single-byte source.
    logic [7:0]  p_data;
    logic        p_empty;
    logic        rd_pe, rd_po;
    logic        tx_pe, tx_po;
    logic        busy_pe, busy_po;
    logic        fd_pe, fd_po;
    logic [15:0] bytes_pe, bytes_po;

    int          checks;
    int          errors;
    int          pops;
    int          fd_cnt;
    int          p_pops_e;
    int          p_pops_o;
    int          fd_cnt_pe;
    int          fd_cnt_po;
    logic        underflow;
    logic [127:0] cap, cape, capo, rdm;
    int          p0, f0;
    logic        bad;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
        .tx(tx), .busy(busy), .frame_done(frame_done), .bytes_sent(bytes_sent)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_data(p_data), .fifo_empty(p_empty), .fifo_read(rd_pe),
        .tx(tx_pe), .busy(busy_pe), .frame_done(fd_pe), .bytes_sent(bytes_pe)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_data(p_data), .fifo_empty(p_empty), .fifo_read(rd_po),
        .tx(tx_po), .busy(busy_po), .frame_done(fd_po), .bytes_sent(bytes_po)
    );

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr[3:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_read) begin
            rd_ptr <= rd_ptr + 8'd1;
            pops   <= pops + 1;
            if (fifo_empty) underflow <= 1'b1;
        end
        if (frame_done) fd_cnt    <= fd_cnt + 1;
        if (rd_pe)      p_pops_e  <= p_pops_e + 1;
        if (rd_po)      p_pops_o  <= p_pops_o + 1;
        if (fd_pe)      fd_cnt_pe <= fd_cnt_pe + 1;
        if (fd_po)      fd_cnt_po <= fd_cnt_po + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each frame bit held for 4 samples; bit 0 of the result is the first sample.
    function automatic logic [127:0] expand(input logic [10:0] bits, input int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++)
            for (int j = 0; j < 4; j++)
                r[4*k+j] = bits[k];
        return r;
    endfunction

    task automatic capture(input int n);
        cap = '0; cape = '0; capo = '0; rdm = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap[i]  = tx;
            cape[i] = tx_pe;
            capo[i] = tx_po;
            rdm[i]  = fifo_read;
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        pops = 0; fd_cnt = 0; p_pops_e = 0; p_pops_o = 0; fd_cnt_pe = 0; fd_cnt_po = 0;
        underflow = 1'b0;
        wr_ptr = 8'd0; rd_ptr = 8'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        p_data = 8'h00; p_empty = 1'b1;
        rst_n = 1'b0; enable = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx",        128'(tx),         128'(1'b1));
        check("rst_busy",      128'(busy),       128'(1'b0));
        check("rst_frame_done",128'(frame_done), 128'(1'b0));
        check("rst_bytes",     128'(bytes_sent), 128'(16'd0));
        check("rst_no_read",   128'(fifo_read),  128'(1'b0));
        rst_n = 1'b1;

        // Empty FIFO, enabled, 100 cycles: idle line, no pops
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_read || !tx || busy) bad = 1'b1;
        end
        check("empty_idle_bad", 128'(bad),        128'(1'b0));
        check("empty_pops",     128'(pops),       128'(0));
        check("empty_bytes",    128'(bytes_sent), 128'(16'd0));

        // Single byte 0xA5: 0,1,0,1,0,0,1,0,1,1 per 4 clks
        p0 = pops; f0 = fd_cnt;
        push(8'hA5);
        capture(40);
        check("a5_wave", cap, expand(11'b01101001010, 10));
        @(negedge clk);
        check("a5_pops",  128'(pops - p0),   128'(1));
        check("a5_done",  128'(fd_cnt - f0), 128'(1));
        check("a5_bytes", 128'(bytes_sent),  128'(16'd1));
        check("a5_busy",  128'(busy),        128'(1'b0));
        check("a5_tx",    128'(tx),          128'(1'b1));

        // Three bytes back-to-back: continuous 120-cycle waveform
        pulse_reset();
        p0 = pops; f0 = fd_cnt;
        push(8'h00); push(8'hFF); push(8'h3C);
        capture(120);
        check("b2b_wave", cap, expand(11'b01000000000, 10) |
                               (expand(11'b01111111110, 10) << 40) |
                               (expand(11'b01001111000, 10) << 80));
        check("b2b_read_slots", rdm, (128'd1 << 39) | (128'd1 << 79));
        @(negedge clk);
        check("b2b_pops",      128'(pops - p0),   128'(3));
        check("b2b_done",      128'(fd_cnt - f0), 128'(3));
        check("b2b_bytes",     128'(bytes_sent),  128'(16'd3));
        check("b2b_empty",     128'(fifo_empty),  128'(1'b1));
        check("b2b_underflow", 128'(underflow),   128'(1'b0));
        check("b2b_busy",      128'(busy),        128'(1'b0));

        // Parity: 0x07 -> even parity 1, odd parity 0, 44-cycle frame.
        // Source byte changes after the pop and must be ignored.
        @(negedge clk);
        p_data = 8'h07; p_empty = 1'b0;
        @(posedge clk);
        #1;
        p_empty = 1'b1; p_data = 8'hFF;
        capture(44);
        check("par_even_wave", cape, expand(11'b11000001110, 11));
        check("par_odd_wave",  capo, expand(11'b10000001110, 11));
        @(negedge clk);
        check("par_even_pops",  128'(p_pops_e),  128'(1));
        check("par_odd_pops",   128'(p_pops_o),  128'(1));
        check("par_even_done",  128'(fd_cnt_pe), 128'(1));
        check("par_odd_done",   128'(fd_cnt_po), 128'(1));
        check("par_even_busy",  128'(busy_pe),   128'(1'b0));
        check("par_odd_busy",   128'(busy_po),   128'(1'b0));
        check("par_even_bytes", 128'(bytes_pe),  128'(16'd1));
        check("par_odd_bytes",  128'(bytes_po),  128'(16'd1));

        // enable dropped mid-DATA with two bytes queued
        pulse_reset();
        p0 = pops;
        push(8'h55); push(8'h81);
        capture(10);
        enable = 1'b0;
        capture(50);
        check("en_wave_first", cap[29:0] | 128'd0,
              128'(expand(11'b01010101010, 10) >> 10) & ((128'd1 << 30) - 128'd1));
        check("en_pops_held", 128'(pops - p0),  128'(1));
        check("en_no_read",   rdm,              128'd0);
        check("en_bytes",     128'(bytes_sent), 128'(16'd1));
        check("en_busy",      128'(busy),       128'(1'b0));
        check("en_tx_idle",   128'(tx),         128'(1'b1));
        enable = 1'b1;
        #1;
        check("en_read_resume", 128'(fifo_read), 128'(1'b1));
        capture(40);
        check("en_wave_second", cap, expand(11'b01100000010, 10));
        @(negedge clk);
        check("en_pops_after",  128'(pops - p0),  128'(2));
        check("en_bytes_after", 128'(bytes_sent), 128'(16'd2));

        // Reset pulsed during DATA: async tx high, counters cleared, next byte sent after release
        p0 = pops;
        push(8'h12); push(8'h34);
        capture(14);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx",    128'(tx),         128'(1'b1));
        check("arst_busy",  128'(busy),       128'(1'b0));
        check("arst_bytes", 128'(bytes_sent), 128'(16'd0));
        repeat (3) @(negedge clk);
        check("arst_no_read", 128'(fifo_read), 128'(1'b0));
        check("arst_pops",    128'(pops - p0), 128'(1));
        rst_n = 1'b1;
        capture(40);
        check("arst_wave", cap, expand(11'b01001101000, 10));
        @(negedge clk);
        check("arst_pops_after", 128'(pops - p0),  128'(2));
        check("arst_bytes_after",128'(bytes_sent), 128'(16'd1));
        check("arst_empty",      128'(fifo_empty), 128'(1'b1));
        check("arst_underflow",  128'(underflow),  128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
